ppu_vram_ctrl: RTL and testbench

PPU_VRAM_CTRL -- requirements
Module: ppu_vram_ctrl

---
 rtl/ppu_vram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ppu_vram_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_ctrl.sv
// PPU nametable VRAM controller: post-reset clear, nametable mirroring, round-robin arbitration of NPORTS requesters.
// Latency: write commits at the grant edge (ack); read data + rvalid one enabled cycle after ack.
// Backpressure: requesters hold req/we/addr/wdata until ack; one grant per enabled cycle; no grants while busy.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clk_en            PPU clock enable; every state element advances only when high
//   mirroring         nametable mode (0 VER, 1 HOR, 2 SINGLE_LO, 3 SINGLE_HI, 4 FOUR, 5-7 act as VER)
//   req, we           per-port request / write-enable
//   addr, wdata       per-port PPU address (16 bits each) and write data (DATA_W each)
//   ack, rvalid       per-port grant pulse / read-data-valid pulse (one enabled cycle each)
//   rdata             shared read data, held until the next read completes
//   busy              high while the post-reset clear sequence runs
module ppu_vram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int NPORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic [2:0]               mirroring,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS*16-1:0]     addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS-1:0]        ack,
  output logic [NPORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy
);

  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_q;
  logic [PW-1:0]       prio_q;     // port with highest priority this cycle
  logic [PW-1:0]       prio_d;
  logic [NPORTS-1:0]   ack_q;
  logic [NPORTS-1:0]   rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                rd_pend_q;
  logic [PW-1:0]       rd_port_q;
  logic [DATA_W-1:0]   rd_buf_q;   // memory read captured at the read's grant edge

  logic [DATA_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------- arbiter
  logic                gnt_vld;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       cand;
  logic [15:0]         gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic                gnt_we;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    // Scan ports starting at prio_q; first requester wins.
    for (int k = 0; k < NPORTS; k++) begin
      cand = PW'((int'(prio_q) + k) % NPORTS);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (state_q != ST_RUN) gnt_vld = 1'b0;
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_vld) prio_d = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;
  end

  assign gnt_addr  = addr[int'(gnt_idx)*16 +: 16];
  assign gnt_wdata = wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign gnt_we    = we[gnt_idx];

  // ------------------------------------------------------ mirroring map
  logic              page;
  logic [11:0]       p12;
  logic [ADDR_W-1:0] paddr;

  always_comb begin
    case (mirroring)
      3'd1:    page = gnt_addr[11];
      3'd2:    page = 1'b0;
      3'd3:    page = 1'b1;
      default: page = gnt_addr[10];   // VER, and FOUR/reserved on a 2 KiB part
    endcase
    // Bit 11 stays 0 for mirrored modes; only FOUR on a 4 KiB part uses it.
    p12 = {1'b0, page, gnt_addr[9:0]};
    if (ADDR_W == 12 && mirroring == 3'd4) p12 = gnt_addr[11:0];
    paddr = p12[ADDR_W-1:0];
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{gnt_addr[15:12], p12};

  // ------------------------------------------------------------ memory
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign mem_we    = clk_en && ((state_q == ST_CLEAR) || (gnt_vld && gnt_we));
  assign mem_re    = clk_en && gnt_vld && !gnt_we;
  assign mem_waddr = (state_q == ST_CLEAR) ? clr_q : paddr;
  assign mem_wdata = (state_q == ST_CLEAR) ? '0 : gnt_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) rd_buf_q <= mem[paddr];
  end

  // ---------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_q     <= '0;
      prio_q    <= '0;
      ack_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_port_q <= '0;
    end else if (clk_en) begin
      ack_q     <= '0;
      rvalid_q  <= '0;
      rd_pend_q <= 1'b0;
      if (rd_pend_q) begin
        rvalid_q[rd_port_q] <= 1'b1;
        rdata_q             <= rd_buf_q;
      end
      case (state_q)
        ST_CLEAR: begin
          clr_q <= clr_q + 1'b1;   // wraps at ADDR_W bits
          if (clr_q == '1) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (gnt_vld) begin
            ack_q[gnt_idx] <= 1'b1;
            prio_q         <= prio_d;
            if (!gnt_we) begin
              rd_pend_q <= 1'b1;
              rd_port_q <= gnt_idx;
            end
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign ack    = ack_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Bench for ppu_vram_ctrl: DUT A (defaults) tracked every cycle by a behavioural model,
// DUT B (ADDR_W=12) exercised with directed four-screen accesses.
module tb_ppu_vram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clk_en = 1'b1;
  logic [2:0]  mir_a, mir_b;
  logic [1:0]  req_a, we_a, ack_a, rv_a;
  logic [1:0]  req_b, we_b, ack_b, rv_b;
  logic [31:0] addr_a, addr_b;
  logic [15:0] wd_a, wd_b;
  logic [7:0]  rd_a, rd_b;
  logic        busy_a, busy_b;

  ppu_vram_ctrl #(.DATA_W(8), .ADDR_W(11), .NPORTS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mirroring(mir_a),
    .req(req_a), .we(we_a), .addr(addr_a), .wdata(wd_a),
    .ack(ack_a), .rvalid(rv_a), .rdata(rd_a), .busy(busy_a)
  );

  ppu_vram_ctrl #(.DATA_W(8), .ADDR_W(12), .NPORTS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mirroring(mir_b),
    .req(req_b), .we(we_b), .addr(addr_b), .wdata(wd_b),
    .ack(ack_b), .rvalid(rv_b), .rdata(rd_b), .busy(busy_b)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit en_slow = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock enable: every cycle, or one cycle in four in slow mode.
  always @(posedge clk) begin
    #2;
    cyc++;
    clk_en = !en_slow || (cyc % 4 == 0);
  end

  // ---------------------------------------------------- behavioural model (DUT A)
  logic [7:0] mmem [2048];
  bit         mbusy;
  int         mclr, mprio, mpend_port;
  bit         mpend;
  logic [7:0] mpend_data, mrdata;
  logic [1:0] mack, mrv;

  function automatic int vmap(input logic [2:0] m, input logic [15:0] a);
    int page;
    case (m)
      3'd1:    page = int'(a[11]);
      3'd2:    page = 0;
      3'd3:    page = 1;
      default: page = int'(a[10]);
    endcase
    return page * 1024 + int'(a[9:0]);
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mmem[i] = 8'h00;
    mbusy = 1'b1; mclr = 0; mprio = 0; mpend = 1'b0; mpend_port = 0;
    mpend_data = 8'h00; mrdata = 8'h00; mack = 2'b00; mrv = 2'b00;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mbusy = 1'b1; mclr = 0; mprio = 0; mpend = 1'b0;
        mack = 2'b00; mrv = 2'b00; mrdata = 8'h00;
      end else if (clk_en) begin
        mack = 2'b00;
        mrv  = 2'b00;
        if (mpend) begin
          mrv[mpend_port] = 1'b1;
          mrdata = mpend_data;
          mpend = 1'b0;
        end
        if (mbusy) begin
          mmem[mclr] = 8'h00;
          if (mclr == 2047) mbusy = 1'b0;
          mclr = (mclr + 1) % 2048;
        end else begin
          for (int k = 0; k < 2; k++) begin
            int p;
            p = (mprio + k) % 2;
            if (mack == 2'b00 && req_a[p]) begin
              int pa;
              mack[p] = 1'b1;
              pa = vmap(mir_a, addr_a[16*p +: 16]);
              if (we_a[p]) mmem[pa] = wd_a[8*p +: 8];
              else begin
                mpend = 1'b1; mpend_port = p; mpend_data = mmem[pa];
              end
              mprio = (p + 1) % 2;
            end
          end
        end
      end
      #1;
      check("ack", int'(ack_a), int'(mack));
      check("rvalid", int'(rv_a), int'(mrv));
      check("rdata", int'(rd_a), int'(mrdata));
      check("busy", int'(busy_a), int'(mbusy));
    end
  end

  // ---------------------------------------------------- stimulus helpers
  task automatic access(input bit b, input int p, input bit w, input logic [15:0] a,
                        input logic [7:0] d, output logic [7:0] rd);
    int n;
    bit got;
    if (b) begin req_b[p] = 1'b1; we_b[p] = w; addr_b[16*p +: 16] = a; wd_b[8*p +: 8] = d; end
    else   begin req_a[p] = 1'b1; we_a[p] = w; addr_a[16*p +: 16] = a; wd_a[8*p +: 8] = d; end
    n = 0; got = 1'b0;
    while (!got && n < 6000) begin
      @(posedge clk); #2; n++;
      got = b ? ack_b[p] : ack_a[p];
    end
    if (!got) check("ack_timeout", 0, 1);
    if (b) req_b[p] = 1'b0; else req_a[p] = 1'b0;
    rd = 8'h00;
    if (!w && got) begin
      n = 0; got = 1'b0;
      while (!got && n < 100) begin
        @(posedge clk); #2; n++;
        got = b ? rv_b[p] : rv_a[p];
      end
      if (!got) check("rvalid_timeout", 0, 1);
      rd = b ? rd_b : rd_a;
    end
  endtask

  task automatic wait_clear(input bit b, output int n);
    n = 0;
    while ((b ? busy_b : busy_a) && n < 10000) begin
      @(posedge clk); #2; n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------- directed sequence
  initial begin
    int n, bad, prev, t, first_ack, first_rv, n_ack, n_rv;
    logic [7:0] d;
    rst_n = 1'b1;
    req_a = '0; we_a = '0; addr_a = '0; wd_a = '0; mir_a = 3'd0;
    req_b = '0; we_b = '0; addr_b = '0; wd_b = '0; mir_b = 3'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", int'(busy_a), 1);
    check("reset_ack", int'(ack_a), 0);
    check("reset_rvalid", int'(rv_a), 0);
    check("reset_rdata", int'(rd_a), 0);
    rst_n = 1'b1;
    wait_clear(1'b0, n);
    check("clear_len", n, 2048);

    // Both ports reading continuously: grants alternate starting at port 0.
    req_a = 2'b11; we_a = 2'b00; addr_a = {16'h2001, 16'h2000};
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      check("rr_ack", int'(ack_a), (i % 2 == 0) ? 1 : 2);
      if (i > 0) check("rv_after_ack", int'(rv_a), prev);
      prev = int'(ack_a);
      if (ack_a[0]) addr_a[15:0]  = addr_a[15:0] + 16'd2;
      if (ack_a[1]) addr_a[31:16] = addr_a[31:16] + 16'd2;
    end
    req_a = 2'b00;
    @(posedge clk); #2;
    check("rv_after_last_ack", int'(rv_a), prev);

    // Every location cleared.
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      access(1'b0, 0, 1'b0, 16'h2000 + 16'(i), 8'h00, d);
      if (d != 8'h00) bad++;
    end
    check("clear_all_zero", bad, 0);

    // Mirroring.
    mir_a = 3'd0;
    access(1'b0, 0, 1'b1, 16'h2005, 8'h5A, d);
    access(1'b0, 0, 1'b0, 16'h2805, 8'h00, d);
    check("ver_2805", int'(d), 'h5A);
    mir_a = 3'd1;
    access(1'b0, 0, 1'b0, 16'h2405, 8'h00, d);
    check("hor_2405", int'(d), 'h5A);
    access(1'b0, 0, 1'b0, 16'h2805, 8'h00, d);
    check("hor_2805", int'(d), 'h00);
    // Read granted right after a write to the same location.
    mir_a = 3'd0;
    access(1'b0, 0, 1'b1, 16'h2100, 8'h3C, d);
    access(1'b0, 1, 1'b0, 16'h2100, 8'h00, d);
    check("raw_bypass", int'(d), 'h3C);
    // FOUR on a 2 KiB part behaves as VER; reserved codes too.
    mir_a = 3'd4;
    access(1'b0, 0, 1'b1, 16'h2C05, 8'h77, d);
    mir_a = 3'd0;
    access(1'b0, 0, 1'b0, 16'h2405, 8'h00, d);
    check("four_as_ver", int'(d), 'h77);
    mir_a = 3'd7;
    access(1'b0, 1, 1'b0, 16'h2C05, 8'h00, d);
    check("reserved_as_ver", int'(d), 'h77);
    mir_a = 3'd2;
    access(1'b0, 0, 1'b0, 16'h2C05, 8'h00, d);
    check("single_lo", int'(d), 'h5A);
    mir_a = 3'd3;
    access(1'b0, 0, 1'b0, 16'h2005, 8'h00, d);
    check("single_hi", int'(d), 'h77);

    // Slow clock enable: pulses span one enabled cycle (4 clk).
    mir_a = 3'd0;
    en_slow = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[31:16] = 16'h2005;
    first_ack = -1; first_rv = -1; n_ack = 0; n_rv = 0;
    for (t = 0; t < 40; t++) begin
      @(posedge clk); #2;
      if (ack_a[1]) begin
        n_ack++;
        if (first_ack < 0) first_ack = t;
        req_a[1] = 1'b0;
      end
      if (rv_a[1]) begin
        n_rv++;
        if (first_rv < 0) first_rv = t;
      end
    end
    req_a[1] = 1'b0;
    check("slow_ack_width", n_ack, 4);
    check("slow_rv_width", n_rv, 4);
    check("slow_ack_to_rv", first_rv - first_ack, 4);
    check("slow_rdata", int'(rd_a), 'h5A);
    en_slow = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Reset while a read is in flight: its rvalid is lost.
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[15:0] = 16'h2005;
    n = 0;
    while (!ack_a[0] && n < 100) begin @(posedge clk); #2; n++; end
    check("inflight_ack_seen", int'(ack_a[0]), 1);
    rst_n = 1'b0;
    req_a = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("inflight_rv_lost", int'(rv_a), 0);
    end
    check("inflight_busy", int'(busy_a), 1);
    rst_n = 1'b1;

    // Reset at clear address 1000: clear restarts from 0.
    repeat (1000) @(posedge clk);
    #2;
    check("mid_clear_busy", int'(busy_a), 1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_clear_reset_busy", int'(busy_a), 1);
    rst_n = 1'b1;
    wait_clear(1'b0, n);
    check("restart_clear_len", n, 2048);
    access(1'b0, 0, 1'b0, 16'h2005, 8'h00, d);
    check("recleared_2005", int'(d), 'h00);

    // Four-screen on a 4 KiB part.
    wait_clear(1'b1, n);
    check("b_ready", int'(busy_b), 0);
    mir_b = 3'd4;
    access(1'b1, 0, 1'b1, 16'h2C00, 8'h11, d);
    access(1'b1, 0, 1'b1, 16'h2400, 8'h22, d);
    access(1'b1, 0, 1'b0, 16'h2C00, 8'h00, d);
    check("four_2C00", int'(d), 'h11);
    access(1'b1, 1, 1'b0, 16'h2400, 8'h00, d);
    check("four_2400", int'(d), 'h22);
    mir_b = 3'd0;
    access(1'b1, 0, 1'b0, 16'h2C00, 8'h00, d);
    check("aw12_ver_bit11_low", int'(d), 'h22);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
